// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the fetch PC, issues word
//                requests to instruction memory over a valid/ready channel,
//                accepts in-order responses, and buffers {pc, instr} pairs
//                toward decode. Redirects flush the buffer and discard any
//                responses still in flight.
//  Ports       : clk, rst_n            clock / async active-low reset
//                imem_req_*            request channel (valid/ready/addr)
//                imem_rsp_*            in-order response (valid/data)
//                redirect_valid/_pc    taken branch/jump restart
//                instr_valid/_ready    decode handshake
//                instr, instr_pc       buffer head word and its PC
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);  // counter width
  localparam int PW = $clog2(DEPTH);      // buffer pointer width (DEPTH >= 2)
  localparam int SW = CW + 1;             // width of outstanding + count sum

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];

  logic          deq;
  logic          accept;
  logic          enq;
  logic [SW-1:0] credit_used;
  logic [31:0]   redirect_aligned;
  logic          unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_valid = (count != '0);
  assign deq         = instr_valid & instr_ready;

  // Every slot is either buffered or reserved by an in-flight request, so the
  // buffer cannot overflow as long as this sum stays below DEPTH. A pop this
  // cycle frees a slot early, which is what sustains one word per cycle.
  assign credit_used    = SW'(outstanding) + SW'(count) - SW'(deq);
  // rst_n gating keeps the request quiet while reset is held.
  assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // Responses are enqueued only when not owed to a pre-redirect request and
  // not arriving in a redirect cycle.
  assign enq = imem_rsp_valid & ~redirect_valid & (drop == '0);

  assign instr    = instr_valid ? buf_data[head] : '0;
  assign instr_pc = instr_valid ? buf_pc[head]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      // No request issues in a redirect cycle; everything still in flight
      // after this cycle's response belongs to the old path.
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop        <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (enq) begin
        rsp_pc <= rsp_pc + 32'd4;
        tail   <= ptr_inc(tail);
      end
      if (deq) begin
        head <= ptr_inc(head);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_data[tail] <= imem_rsp_data;
      buf_pc[tail]   <= rsp_pc;
    end
  end

endmodule
`default_nettype wire
